daq_packetizer_gen: RTL and testbench

//  Parametrised successor of the fixed 8x8 AD7606 packetizer. After each conversion it reads a

---
 rtl/daq_packetizer_gen_pkg.sv | 34 +++
 rtl/daq_packetizer_gen_if.sv | 24 ++
 rtl/daq_packetizer_gen_rd_strobe.sv | 81 ++++++++
 rtl/daq_packetizer_gen.sv | 238 +++++++++++++++++++++++
 tb/tb_daq_packetizer_gen.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/daq_packetizer_gen_pkg.sv
// daq_packetizer_gen_pkg
//   Shared types and defaults for the parametrised AD7606-style packetizer.
//   - pkt_state_t : packetizer FSM states
//   - rd_phase_t  : read-strobe timer phases
//   - idx_w()     : index width helper that never returns 0 (safe for N=1)
package daq_packetizer_gen_pkg;

  localparam int unsigned DW_DEFAULT       = 16;
  localparam logic [15:0] PREAMBLE_DEFAULT = 16'hAAAA;

  typedef enum logic [3:0] {
    S_IDLE,
    S_BUSY_HI,
    S_BUSY_LO,
    S_HDR_PRE,
    S_HDR_CNT,
    S_CS_SETUP,
    S_RD_WAIT,
    S_LAST_RISE,
    S_CS_GAP,
    S_CKSUM
  } pkt_state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_LO,
    P_HI
  } rd_phase_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/daq_packetizer_gen_if.sv
// daq_packetizer_gen_if
//   Write-side connection between the packetizer and the downstream FIFO.
//   fifo_wr_o   : 1-cycle write strobe (packetizer -> FIFO)
//   fifo_data_o : write data, valid with fifo_wr_o (packetizer -> FIFO)
//   fifo_afull_i: FIFO cannot take a full packet (FIFO -> packetizer)
interface daq_packetizer_gen_if #(
  parameter int unsigned DW = 16
);
  logic          fifo_wr_o;
  logic [DW-1:0] fifo_data_o;
  logic          fifo_afull_i;

  modport master (
    output fifo_wr_o,
    output fifo_data_o,
    input  fifo_afull_i
  );

  modport slave (
    input  fifo_wr_o,
    input  fifo_data_o,
    output fifo_afull_i
  );
endinterface

// File: rtl/daq_packetizer_gen_rd_strobe.sv
// daq_rd_strobe
//   Generates the shared active-low ADC read strobe for one word per start.
//   rd_n_o is held low RD_LO_CYC cycles, then high RD_HI_CYC cycles.
//   clk_i, reset_n_i : clock, async active-low reset
//   start_i          : request a word; accepted when idle_o or done_o
//   rd_n_o           : read strobe (registered)
//   sample_o         : high during the last low cycle (capture db at its end)
//   done_o           : high during the last high cycle
//   idle_o           : no word in progress
module daq_rd_strobe
  import daq_packetizer_gen_pkg::*;
#(
  parameter int unsigned RD_LO_CYC = 4,
  parameter int unsigned RD_HI_CYC = 2
) (
  input  logic clk_i,
  input  logic reset_n_i,
  input  logic start_i,
  output logic rd_n_o,
  output logic sample_o,
  output logic done_o,
  output logic idle_o
);

  localparam int unsigned CNT_MAX = (RD_LO_CYC > RD_HI_CYC) ? RD_LO_CYC : RD_HI_CYC;
  localparam int unsigned CNT_W   = idx_w(CNT_MAX);

  rd_phase_t        phase_q;
  logic [CNT_W-1:0] cnt_q;

  assign sample_o = (phase_q == P_LO) && (cnt_q == '0);
  assign done_o   = (phase_q == P_HI) && (cnt_q == '0);
  assign idle_o   = (phase_q == P_IDLE);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      phase_q <= P_IDLE;
      cnt_q   <= '0;
      rd_n_o  <= 1'b1;
    end else begin
      case (phase_q)
        P_IDLE: begin
          if (start_i) begin
            phase_q <= P_LO;
            cnt_q   <= CNT_W'(RD_LO_CYC - 1);
            rd_n_o  <= 1'b0;
          end
        end
        P_LO: begin
          if (cnt_q == '0) begin
            phase_q <= P_HI;
            cnt_q   <= CNT_W'(RD_HI_CYC - 1);
            rd_n_o  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        P_HI: begin
          if (cnt_q == '0) begin
            // Chaining straight into the next low phase keeps the high time
            // at exactly RD_HI_CYC between back-to-back words.
            if (start_i) begin
              phase_q <= P_LO;
              cnt_q   <= CNT_W'(RD_LO_CYC - 1);
              rd_n_o  <= 1'b0;
            end else begin
              phase_q <= P_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          phase_q <= P_IDLE;
          rd_n_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/daq_packetizer_gen.sv
// daq_packetizer_gen
//   Reads a masked subset of DAQCOUNT parallel-bus ADCs (CHANS words each)
//   after every conversion and writes a framed packet to the FIFO:
//   PREAMBLE, packet count, data words (device/channel order), checksum.
//   clk_i, reset_n_i  : clock, async active-low reset
//   en_i, conv_start_i: conversion accept enable, CONVST pulse
//   busy_i, db_i      : shared ADC BUSY and data bus
//   daq_mask_i        : device include mask, latched at conversion start
//   cs_n_o, rd_n_o    : per-device chip selects, shared read strobe
//   fifo              : FIFO write port (wr strobe, data, almost-full)
//   pkt_count_o       : packets emitted (wraps)
//   drop_count_o      : packets dropped for almost-full (saturates)
//   overrun_o         : sticky, conversion seen while busy
//   busy_to_o         : sticky, BUSY rise/fall timeout
//   active_o          : packetizer not idle
module daq_packetizer_gen
  import daq_packetizer_gen_pkg::*;
#(
  parameter int unsigned   DAQCOUNT  = 8,
  parameter int unsigned   CHANS     = 8,
  parameter int unsigned   DW        = DW_DEFAULT,
  parameter int unsigned   RD_LO_CYC = 4,
  parameter int unsigned   RD_HI_CYC = 2,
  parameter int unsigned   BUSY_TO   = 4096,
  parameter logic [DW-1:0] PREAMBLE  = DW'(PREAMBLE_DEFAULT)
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic                en_i,
  input  logic                conv_start_i,
  input  logic                busy_i,
  input  logic [DW-1:0]       db_i,
  input  logic [DAQCOUNT-1:0] daq_mask_i,
  output logic [DAQCOUNT-1:0] cs_n_o,
  output logic                rd_n_o,
  daq_packetizer_gen_if.master fifo,
  output logic [15:0]         pkt_count_o,
  output logic [15:0]         drop_count_o,
  output logic                overrun_o,
  output logic                busy_to_o,
  output logic                active_o
);

  localparam int unsigned DEV_W  = idx_w(DAQCOUNT);
  localparam int unsigned WORD_W = idx_w(CHANS);
  localparam int unsigned TMR_W  = idx_w(BUSY_TO);

  pkt_state_t          state_q;
  logic [DAQCOUNT-1:0] mask_q;
  logic [DEV_W-1:0]    dev_q;
  logic [WORD_W-1:0]   word_q;
  logic [TMR_W-1:0]    timer_q;
  logic [DW-1:0]       cksum_q;

  logic                rd_start, rd_sample, rd_done, rd_idle, rd_ready;
  logic                first_vld, nxt_vld;
  logic [DEV_W-1:0]    first_dev, nxt_dev;
  logic                timer_exp;

  assign rd_start  = (state_q == S_CS_SETUP);
  assign rd_ready  = rd_idle | rd_done;
  assign timer_exp = (timer_q == TMR_W'(BUSY_TO - 1));

  daq_rd_strobe #(
    .RD_LO_CYC (RD_LO_CYC),
    .RD_HI_CYC (RD_HI_CYC)
  ) u_rd_strobe (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .start_i   (rd_start),
    .rd_n_o    (rd_n_o),
    .sample_o  (rd_sample),
    .done_o    (rd_done),
    .idle_o    (rd_idle)
  );

  // Lowest included device overall, and lowest included device above dev_q.
  // Scanning from the top down lets the lowest match overwrite the others.
  always_comb begin
    first_vld = 1'b0;
    first_dev = '0;
    nxt_vld   = 1'b0;
    nxt_dev   = '0;
    for (int unsigned i = 0; i < DAQCOUNT; i++) begin
      if (mask_q[DAQCOUNT-1-i]) begin
        first_vld = 1'b1;
        first_dev = DEV_W'(DAQCOUNT - 1 - i);
        if ((DAQCOUNT - 1 - i) > 32'(dev_q)) begin
          nxt_vld = 1'b1;
          nxt_dev = DEV_W'(DAQCOUNT - 1 - i);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q          <= S_IDLE;
      mask_q           <= '0;
      dev_q            <= '0;
      word_q           <= '0;
      timer_q          <= '0;
      cksum_q          <= '0;
      cs_n_o           <= '1;
      fifo.fifo_wr_o   <= 1'b0;
      fifo.fifo_data_o <= '0;
      pkt_count_o      <= '0;
      drop_count_o     <= '0;
      overrun_o        <= 1'b0;
      busy_to_o        <= 1'b0;
      active_o         <= 1'b0;
    end else begin
      fifo.fifo_wr_o <= 1'b0;
      if (conv_start_i && (state_q != S_IDLE)) begin
        overrun_o <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (conv_start_i && en_i) begin
            mask_q   <= daq_mask_i;
            timer_q  <= '0;
            active_o <= 1'b1;
            state_q  <= S_BUSY_HI;
          end
        end

        S_BUSY_HI: begin
          if (busy_i) begin
            timer_q <= '0;
            state_q <= S_BUSY_LO;
          end else if (timer_exp) begin
            busy_to_o <= 1'b1;
            active_o  <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        S_BUSY_LO: begin
          if (!busy_i) begin
            if (fifo.fifo_afull_i) begin
              if (drop_count_o != 16'hFFFF) begin
                drop_count_o <= drop_count_o + 1'b1;
              end
              active_o <= 1'b0;
              state_q  <= S_IDLE;
            end else begin
              fifo.fifo_wr_o   <= 1'b1;
              fifo.fifo_data_o <= PREAMBLE;
              state_q          <= S_HDR_PRE;
            end
          end else if (timer_exp) begin
            busy_to_o <= 1'b1;
            active_o  <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        S_HDR_PRE: begin
          fifo.fifo_wr_o   <= 1'b1;
          fifo.fifo_data_o <= DW'(pkt_count_o);
          cksum_q          <= DW'(pkt_count_o);
          state_q          <= S_HDR_CNT;
        end

        S_HDR_CNT: begin
          word_q <= '0;
          if (first_vld) begin
            dev_q   <= first_dev;
            cs_n_o  <= ~(DAQCOUNT'(1) << first_dev);
            state_q <= S_CS_SETUP;
          end else begin
            fifo.fifo_wr_o   <= 1'b1;
            fifo.fifo_data_o <= cksum_q;
            state_q          <= S_CKSUM;
          end
        end

        // rd_start is asserted here; the strobe accepts it once ready.
        S_CS_SETUP: begin
          if (rd_ready) begin
            state_q <= S_RD_WAIT;
          end
        end

        S_RD_WAIT: begin
          if (rd_sample) begin
            fifo.fifo_wr_o   <= 1'b1;
            fifo.fifo_data_o <= db_i;
            cksum_q          <= cksum_q + db_i;
            if (word_q == WORD_W'(CHANS - 1)) begin
              state_q <= S_LAST_RISE;
            end else begin
              word_q  <= word_q + 1'b1;
              state_q <= S_CS_SETUP;
            end
          end
        end

        // First cycle with rd_n high after the device's last word.
        S_LAST_RISE: begin
          cs_n_o  <= '1;
          state_q <= S_CS_GAP;
        end

        S_CS_GAP: begin
          word_q <= '0;
          if (nxt_vld) begin
            dev_q   <= nxt_dev;
            cs_n_o  <= ~(DAQCOUNT'(1) << nxt_dev);
            state_q <= S_CS_SETUP;
          end else begin
            fifo.fifo_wr_o   <= 1'b1;
            fifo.fifo_data_o <= cksum_q;
            state_q          <= S_CKSUM;
          end
        end

        S_CKSUM: begin
          pkt_count_o <= pkt_count_o + 1'b1;
          active_o    <= 1'b0;
          state_q     <= S_IDLE;
        end

        default: begin
          cs_n_o   <= '1;
          active_o <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_daq_packetizer_gen.sv
module tb_daq_packetizer_gen;
  import daq_packetizer_gen_pkg::*;

  localparam int unsigned NDEV = 8;
  localparam int unsigned NCH  = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en, conv_start, busy;
  logic [15:0] db;
  logic [7:0]  mask;
  logic [7:0]  cs_n;
  logic        rd_n;
  logic [15:0] pkt_count, drop_count;
  logic        overrun, busy_to, active;

  daq_packetizer_gen_if #(.DW(16)) fifo_if();

  always #5 clk = ~clk;

  daq_packetizer_gen #(
    .DAQCOUNT  (NDEV),
    .CHANS     (NCH),
    .DW        (16),
    .RD_LO_CYC (4),
    .RD_HI_CYC (2),
    .BUSY_TO   (4096),
    .PREAMBLE  (16'hAAAA)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .en_i         (en),
    .conv_start_i (conv_start),
    .busy_i       (busy),
    .db_i         (db),
    .daq_mask_i   (mask),
    .cs_n_o       (cs_n),
    .rd_n_o       (rd_n),
    .fifo         (fifo_if),
    .pkt_count_o  (pkt_count),
    .drop_count_o (drop_count),
    .overrun_o    (overrun),
    .busy_to_o    (busy_to),
    .active_o     (active)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  int          wr_total = 0;
  int          multi_low = 0;
  logic [7:0]  cs_seen = '0;
  logic [15:0] seed = 16'h0100;
  logic [15:0] exp_pkt = '0;
  int          adc_w = 0;
  logic        rd_prev = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] adc_word(input logic [15:0] s, input int d, input int w);
    return s + 16'(d * 256) + 16'(w * 3);
  endfunction

  function automatic int low_idx(input logic [7:0] c);
    for (int i = NDEV - 1; i >= 0; i--) begin
      if (!c[i]) return i;
    end
    return 0;
  endfunction

  // ADC bus model: each device returns a ramp indexed by device and word.
  always @(negedge clk) begin
    if (!reset_n) begin
      adc_w = 0;
    end else if (&cs_n) begin
      adc_w = 0;
    end else if (rd_prev && !rd_n) begin
      db = adc_word(seed, low_idx(cs_n), adc_w);
      adc_w++;
    end
    rd_prev = rd_n;
  end

  // Monitor: compares every FIFO write against the scoreboard queue.
  always @(negedge clk) begin
    logic [15:0] exp_w;
    if (reset_n) begin
      if ($countones(~cs_n) > 1) multi_low++;
      cs_seen = cs_seen | ~cs_n;
      if (fifo_if.fifo_wr_o) begin
        wr_total++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write actual=%h expected=none", fifo_if.fifo_data_o);
        end else begin
          exp_w = exp_q.pop_front();
          chk("fifo_word", 32'(fifo_if.fifo_data_o), 32'(exp_w));
        end
      end
    end
  end

  task automatic push_packet(input logic [7:0] m);
    logic [15:0] ck;
    exp_q.push_back(16'hAAAA);
    exp_q.push_back(exp_pkt);
    ck = exp_pkt;
    for (int d = 0; d < NDEV; d++) begin
      if (m[d]) begin
        for (int w = 0; w < NCH; w++) begin
          exp_q.push_back(adc_word(seed, d, w));
          ck = ck + adc_word(seed, d, w);
        end
      end
    end
    exp_q.push_back(ck);
    exp_pkt = exp_pkt + 16'd1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (active && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      failures++;
      $display("FAIL idle_wait actual=active expected=idle");
    end
  endtask

  task automatic pulse_conv(input logic [7:0] m);
    @(negedge clk);
    mask = m;
    conv_start = 1'b1;
    @(negedge clk);
    conv_start = 1'b0;
  endtask

  task automatic busy_pulse();
    repeat (2) @(negedge clk);
    busy = 1'b1;
    repeat (4) @(negedge clk);
    busy = 1'b0;
  endtask

  task automatic wait_rd_low();
    int n = 0;
    while (rd_n && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      failures++;
      $display("FAIL rd_wait actual=rd_n_high expected=rd_n_low");
    end
  endtask

  task automatic do_conv(input logic [7:0] m, input logic af, input logic ovr);
    fifo_if.fifo_afull_i = af;
    pulse_conv(m);
    busy_pulse();
    if (ovr) begin
      wait_rd_low();
      conv_start = 1'b1;
      @(negedge clk);
      conv_start = 1'b0;
    end
    wait_idle();
    @(negedge clk);
    fifo_if.fifo_afull_i = 1'b0;
  endtask

  int w0;

  initial begin
    reset_n = 1'b0;
    en = 1'b1;
    conv_start = 1'b0;
    busy = 1'b0;
    mask = '0;
    db = '0;
    fifo_if.fifo_afull_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", 32'(cs_n), 32'h000000FF);
    chk("rst_rd_n", 32'(rd_n), 32'd1);
    chk("rst_wr", 32'(fifo_if.fifo_wr_o), 32'd0);
    chk("rst_data", 32'(fifo_if.fifo_data_o), 32'd0);
    chk("rst_pkt", 32'(pkt_count), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_flags", {29'd0, overrun, busy_to, active}, 32'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full mask, 67-word packet.
    seed = 16'h0100;
    w0 = wr_total;
    push_packet(8'hFF);
    do_conv(8'hFF, 1'b0, 1'b0);
    chk("t1_words", 32'(wr_total - w0), 32'd67);
    chk("t1_pkt", 32'(pkt_count), 32'd1);
    chk("t1_drain", 32'(exp_q.size()), 32'd0);

    // Partial mask and empty mask.
    seed = 16'h1234;
    cs_seen = '0;
    w0 = wr_total;
    push_packet(8'h05);
    do_conv(8'h05, 1'b0, 1'b0);
    chk("t2_words", 32'(wr_total - w0), 32'd19);
    chk("t2_cs_seen", 32'(cs_seen), 32'h05);
    cs_seen = '0;
    w0 = wr_total;
    push_packet(8'h00);
    do_conv(8'h00, 1'b0, 1'b0);
    chk("t2_zero_words", 32'(wr_total - w0), 32'd3);
    chk("t2_zero_cs", 32'(cs_seen), 32'h00);

    // Almost-full drop, then recovery.
    w0 = wr_total;
    do_conv(8'hFF, 1'b1, 1'b0);
    chk("t3_drop_words", 32'(wr_total - w0), 32'd0);
    chk("t3_drop_cnt", 32'(drop_count), 32'd1);
    chk("t3_pkt_held", 32'(pkt_count), 32'd3);
    push_packet(8'h0F);
    do_conv(8'h0F, 1'b0, 1'b0);
    chk("t3_pkt_after", 32'(pkt_count), 32'd4);

    // Overrun during reads; packet must stay intact. Large seed wraps the sum.
    chk("t5_ovr_before", 32'(overrun), 32'd0);
    seed = 16'hF800;
    push_packet(8'h81);
    do_conv(8'h81, 1'b0, 1'b1);
    chk("t5_ovr_set", 32'(overrun), 32'd1);
    chk("t5_drain", 32'(exp_q.size()), 32'd0);
    chk("t5_pkt", 32'(pkt_count), 32'd5);

    // Disabled: conversion ignored.
    en = 1'b0;
    w0 = wr_total;
    pulse_conv(8'hFF);
    busy_pulse();
    repeat (5) @(negedge clk);
    chk("en_off_active", 32'(active), 32'd0);
    chk("en_off_words", 32'(wr_total - w0), 32'd0);
    en = 1'b1;

    // Packet counter wrap.
    force dut.pkt_count_o = 16'hFFFF;
    @(negedge clk);
    release dut.pkt_count_o;
    exp_pkt = 16'hFFFF;
    push_packet(8'h00);
    do_conv(8'h00, 1'b0, 1'b0);
    chk("t6_wrap", 32'(pkt_count), 32'd0);
    seed = 16'h0040;
    push_packet(8'h02);
    do_conv(8'h02, 1'b0, 1'b0);
    chk("t6_after_wrap", 32'(pkt_count), 32'd1);

    // BUSY never rises: still waiting just before the limit, timed out after.
    w0 = wr_total;
    pulse_conv(8'hFF);
    repeat (4000) @(negedge clk);
    chk("t4_pre_to_active", 32'(active), 32'd1);
    chk("t4_pre_to_flag", 32'(busy_to), 32'd0);
    repeat (200) @(negedge clk);
    chk("t4_to_flag", 32'(busy_to), 32'd1);
    chk("t4_to_idle", 32'(active), 32'd0);
    chk("t4_to_words", 32'(wr_total - w0), 32'd0);

    // Asynchronous reset in the middle of the reads.
    seed = 16'h0300;
    push_packet(8'hFF);
    pulse_conv(8'hFF);
    busy_pulse();
    wait_rd_low();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t5r_cs_n", 32'(cs_n), 32'h000000FF);
    chk("t5r_rd_n", 32'(rd_n), 32'd1);
    chk("t5r_pkt", 32'(pkt_count), 32'd0);
    chk("t5r_flags", {29'd0, overrun, busy_to, active}, 32'd0);
    exp_q.delete();
    exp_pkt = '0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // BUSY stuck high.
    w0 = wr_total;
    busy = 1'b1;
    pulse_conv(8'hFF);
    repeat (4200) @(negedge clk);
    chk("t4b_to_flag", 32'(busy_to), 32'd1);
    chk("t4b_to_idle", 32'(active), 32'd0);
    chk("t4b_to_words", 32'(wr_total - w0), 32'd0);
    busy = 1'b0;
    repeat (2) @(negedge clk);

    // Normal packet after reset starts counting from 0 again.
    seed = 16'h0777;
    push_packet(8'h80);
    do_conv(8'h80, 1'b0, 1'b0);
    chk("final_pkt", 32'(pkt_count), 32'd1);
    chk("final_drain", 32'(exp_q.size()), 32'd0);
    chk("one_cs_low", 32'(multi_low), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
